// File: rtl/dbg_pkg.sv
// Shared types and constants for the board debug unit: FSM states and
// the active-low seven-segment glyph table.
package dbg_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } dbg_state_e;

    // Glyphs for 0..F, entry n at bits [n*8 +: 8]; bit7..bit1 = a..g, bit0 = dp (off)
    localparam logic [127:0] HEX_SEG = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        return HEX_SEG[{nib, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dbg_unit_p_btn_cond.sv
// Pushbutton conditioner: two-flop synchroniser, counting debouncer and a
// registered one-cycle rising-edge pulse.
module btn_cond #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    localparam int CNT_W = $clog2(DB_CYC + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;

    // Level flips only after DB_CYC consecutive cycles of disagreement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            pulse_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_W'(DB_CYC - 1)) begin
                    level_r <= sync2_r;
                    cnt_r   <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            level_d_r <= level_r;
            pulse_r   <= level_r & ~level_d_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/dbg_unit_p.sv
// Board debug unit: CPU clock-enable control (run/step/breakpoint), browse
// address counter, watch-channel display mux and multiplexed hex scanner.
module dbg_unit_p
    import dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int NCH    = 8,
    parameter int DIGITS = 8,
    parameter int SCAN_W = 18,
    parameter int DB_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     step,
    input  logic                     inc,
    input  logic                     dec,
    input  logic                     m_rf,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic                     bp_en,
    input  logic [DATA_W-1:0]        bp_addr,
    input  logic [DATA_W-1:0]        pc,
    input  logic [DATA_W-1:0]        m_data,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic [NCH*DATA_W-1:0]    ch_data,
    input  logic [15:0]              ctrl_bits,
    output logic                     cpu_en,
    output logic                     halted_bp,
    output logic [ADDR_W-1:0]        m_rf_addr,
    output logic [15:0]              led,
    output logic [7:0]               seg_ca,
    output logic [DIGITS-1:0]        seg_an
);

    localparam int SEL_W  = $clog2(NCH);
    localparam int DIG_W  = $clog2(DIGITS);
    localparam int DISP_W = DIGITS * 4;

    logic               step_p_s;
    logic               inc_p_s;
    logic               dec_p_s;
    logic               run_sync1_r;
    logic               run_sync2_r;
    dbg_state_e         state_r;
    logic               cpu_en_r;
    logic               halted_bp_r;
    logic               armed_r;
    logic               bp_hit_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  word_s;
    logic [DISP_W-1:0]  word_r;
    logic [SCAN_W-1:0]  scan_r;
    logic [DIG_W-1:0]   digit_s;
    logic [DIGITS-1:0]  seg_an_r;
    logic [7:0]         seg_ca_r;
    logic [15:0]        led_s;

    btn_cond #(.DB_CYC(DB_CYC)) u_step (.clk(clk), .rst(rst), .din(step), .pulse(step_p_s));
    btn_cond #(.DB_CYC(DB_CYC)) u_inc  (.clk(clk), .rst(rst), .din(inc),  .pulse(inc_p_s));
    btn_cond #(.DB_CYC(DB_CYC)) u_dec  (.clk(clk), .rst(rst), .din(dec),  .pulse(dec_p_s));

    // The run switch is a level, so it needs synchronising but no debounce
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sync1_r <= 1'b0;
            run_sync2_r <= 1'b0;
        end else begin
            run_sync1_r <= run;
            run_sync2_r <= run_sync1_r;
        end
    end

    // Combinational on pc so the CPU is frozen in the very cycle it reaches the breakpoint
    assign bp_hit_s = (state_r == RUN) && bp_en && armed_r && (pc == bp_addr);

    // Run/step/breakpoint control FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= HALT;
            cpu_en_r    <= 1'b0;
            halted_bp_r <= 1'b0;
        end else begin
            case (state_r)
                HALT: begin
                    if (run_sync2_r) begin
                        state_r     <= RUN;
                        cpu_en_r    <= 1'b1;
                        halted_bp_r <= 1'b0;
                    end else if (step_p_s) begin
                        state_r     <= STEP;
                        cpu_en_r    <= 1'b1;
                        halted_bp_r <= 1'b0;
                    end else begin
                        state_r  <= HALT;
                        cpu_en_r <= 1'b0;
                    end
                end
                STEP: begin
                    state_r  <= HALT;
                    cpu_en_r <= 1'b0;
                end
                RUN: begin
                    if (!run_sync2_r) begin
                        state_r  <= HALT;
                        cpu_en_r <= 1'b0;
                    end else if (bp_hit_s) begin
                        state_r     <= HALT;
                        cpu_en_r    <= 1'b0;
                        halted_bp_r <= 1'b1;
                    end else begin
                        state_r  <= RUN;
                        cpu_en_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= HALT;
                    cpu_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Re-arm only once the PC has moved off the breakpoint, so resuming there does not re-trigger
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_r <= 1'b0;
        end else if (pc != bp_addr) begin
            armed_r <= 1'b1;
        end else if (bp_hit_s) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Browse address: wraps both ways, simultaneous inc/dec cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (inc_p_s && !dec_p_s) begin
            addr_r <= addr_r + 1'b1;
        end else if (dec_p_s && !inc_p_s) begin
            addr_r <= addr_r - 1'b1;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Channel 0 carries the browse data instead of a watch word
    always_comb begin
        word_s = {DATA_W{1'b0}};
        if (sel == {SEL_W{1'b0}}) begin
            if (m_rf) begin
                word_s = m_data;
            end else begin
                word_s = rf_data;
            end
        end else begin
            word_s = ch_data[sel*DATA_W +: DATA_W];
        end
    end

    assign digit_s = scan_r[SCAN_W-1 -: DIG_W];

    // Display word capture and digit scanner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_r   <= {DISP_W{1'b0}};
            scan_r   <= {SCAN_W{1'b0}};
            seg_an_r <= {DIGITS{1'b1}};
            seg_ca_r <= SEG_BLANK;
        end else begin
            word_r   <= DISP_W'(word_s);
            scan_r   <= scan_r + 1'b1;
            seg_an_r <= ~(DIGITS'(1'b1) << digit_s);
            seg_ca_r <= hex_seg(word_r[{digit_s, 2'b00} +: 4]);
        end
    end

    // LEDs show the word-aligned browse address on channel 0, else the control vector
    always_comb begin
        led_s = ctrl_bits;
        if (sel == {SEL_W{1'b0}}) begin
            led_s = 16'({addr_r, 2'b00});
        end else begin
            led_s = ctrl_bits;
        end
    end

    assign cpu_en    = cpu_en_r & ~bp_hit_s;
    assign halted_bp = halted_bp_r;
    assign m_rf_addr = addr_r;
    assign led       = led_s;
    assign seg_ca    = seg_ca_r;
    assign seg_an    = seg_an_r;

endmodule

// File: tb/tb_dbg_unit_p.sv
// Self-checking bench for dbg_unit_p: directed FSM/breakpoint scenarios plus
// randomized browse-address and display traffic against a behavioural model.
`timescale 1ns/1ps
module tb_dbg_unit_p;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int NCH    = 8;
    localparam int DIGITS = 8;
    localparam int SCAN_W = 6;
    localparam int DB_CYC = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  run = 1'b0;
    logic                  step = 1'b0;
    logic                  inc = 1'b0;
    logic                  dec = 1'b0;
    logic                  m_rf = 1'b0;
    logic [2:0]            sel = 3'd0;
    logic                  bp_en = 1'b0;
    logic [DATA_W-1:0]     bp_addr = 32'd0;
    logic [DATA_W-1:0]     pc = 32'd0;
    logic [DATA_W-1:0]     m_data = 32'd0;
    logic [DATA_W-1:0]     rf_data = 32'd0;
    logic [NCH*DATA_W-1:0] ch_data = '0;
    logic [15:0]           ctrl_bits = 16'd0;
    logic                  cpu_en;
    logic                  halted_bp;
    logic [ADDR_W-1:0]     m_rf_addr;
    logic [15:0]           led;
    logic [7:0]            seg_ca;
    logic [DIGITS-1:0]     seg_an;

    int n_vec = 0;
    int n_err = 0;
    int addr_ref = 0;
    logic [7:0] seg_ref [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    dbg_unit_p #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH),
        .DIGITS(DIGITS), .SCAN_W(SCAN_W), .DB_CYC(DB_CYC)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .inc(inc), .dec(dec),
        .m_rf(m_rf), .sel(sel), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .m_data(m_data), .rf_data(rf_data), .ch_data(ch_data), .ctrl_bits(ctrl_bits),
        .cpu_en(cpu_en), .halted_bp(halted_bp), .m_rf_addr(m_rf_addr), .led(led),
        .seg_ca(seg_ca), .seg_an(seg_an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean button press: held long enough to debounce, then released
    task automatic press(input logic do_inc, input logic do_dec);
        @(negedge clk);
        inc = do_inc;
        dec = do_dec;
        cyc(12);
        inc = 1'b0;
        dec = 1'b0;
        cyc(12);
        if (do_inc && !do_dec) addr_ref = (addr_ref + 1) % 512;
        else if (do_dec && !do_inc) addr_ref = (addr_ref + 511) % 512;
    endtask

    function automatic logic [15:0] led_model(input logic [2:0] s, input logic [15:0] cb);
        if (s == 3'd0) return 16'((addr_ref * 4) & 32'hFFFF);
        return cb;
    endfunction

    // Watch one full scan period: one anode low, glyph matches nibble, digits advance in order
    task automatic check_scan(input string tag, input logic [31:0] word);
        int d;
        int zeros;
        int prev;
        int runlen;
        bit started;
        logic [7:0] seen;
        prev = -1;
        runlen = 0;
        started = 1'b0;
        seen = 8'h00;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            #1;
            d = -1;
            zeros = 0;
            for (int b = 0; b < DIGITS; b++) begin
                if (!seg_an[b]) begin
                    d = b;
                    zeros++;
                end
            end
            check({tag, "_an1hot"}, 64'(zeros), 64'd1);
            if (d < 0) d = 0;
            seen[d] = 1'b1;
            check({tag, "_ca"}, 64'(seg_ca), 64'(seg_ref[4'((word >> (4 * d)) & 32'hF)]));
            if (prev >= 0 && d != prev) begin
                check({tag, "_order"}, 64'(d), 64'((prev + 1) % DIGITS));
                if (started) check({tag, "_dwell"}, 64'(runlen), 64'd8);
                started = 1'b1;
                runlen = 0;
            end
            runlen++;
            prev = d;
        end
        check({tag, "_all_digits"}, 64'(seen), 64'hFF);
    endtask

    initial begin
        int hi_cnt;
        int hi_at;
        int waited;
        int r;
        logic [2:0]  rs;
        logic [31:0] w;

        // Reset state
        #2 rst = 1'b0;
        cyc(3);
        #1;
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_halted", 64'(halted_bp), 64'd0);
        check("rst_addr", 64'(m_rf_addr), 64'd0);
        check("rst_an", 64'(seg_an), 64'hFF);
        check("rst_ca", 64'(seg_ca), 64'hFF);
        check("rst_led", 64'(led), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(3);

        // Single step: exactly one enable cycle, DB_CYC+4 cycles after the raw edge
        @(negedge clk);
        step = 1'b1;
        hi_cnt = 0;
        hi_at = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            if (cpu_en) begin
                hi_cnt++;
                if (hi_at < 0) hi_at = k;
            end
        end
        check("step_count", 64'(hi_cnt), 64'd1);
        check("step_latency", 64'(hi_at), 64'(DB_CYC + 4));
        step = 1'b0;
        cyc(12);
        #1;
        check("step_back_halt", 64'(cpu_en), 64'd0);

        // Breakpoint hit
        bp_en = 1'b1;
        bp_addr = 32'h0C;
        pc = 32'd0;
        run = 1'b1;
        cyc(5);
        #1;
        check("run_en", 64'(cpu_en), 64'd1);
        @(negedge clk); pc = 32'd4; #1; check("run_pc4", 64'(cpu_en), 64'd1);
        @(negedge clk); pc = 32'd8; #1; check("run_pc8", 64'(cpu_en), 64'd1);
        @(negedge clk); pc = 32'h0C; #1; check("bp_drop", 64'(cpu_en), 64'd0);
        @(negedge clk); #1;
        check("bp_halted", 64'(halted_bp), 64'd1);
        check("bp_stays_off", 64'(cpu_en), 64'd0);

        // Resume at the breakpoint PC: no re-trigger until pc leaves and returns
        run = 1'b0;
        cyc(5);
        run = 1'b1;
        cyc(5);
        #1;
        check("resume_en", 64'(cpu_en), 64'd1);
        check("resume_clr", 64'(halted_bp), 64'd0);
        cyc(3);
        #1;
        check("no_retrigger", 64'(cpu_en), 64'd1);
        @(negedge clk); pc = 32'h10; #1; check("leave_bp", 64'(cpu_en), 64'd1);
        @(negedge clk); pc = 32'h0C; #1; check("retrigger", 64'(cpu_en), 64'd0);
        @(negedge clk); #1; check("retrig_halted", 64'(halted_bp), 64'd1);
        run = 1'b0;
        bp_en = 1'b0;
        cyc(5);

        // Browse address: wrap below zero, cancellation, then random traffic
        sel = 3'd0;
        repeat (3) press(1'b0, 1'b1);
        #1;
        check("dec3_addr", 64'(m_rf_addr), 64'h1FD);
        check("dec3_led", 64'(led), 64'h07F4);
        press(1'b1, 1'b1);
        #1;
        check("incdec_addr", 64'(m_rf_addr), 64'h1FD);
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 2));
            press(r != 1, r != 0);
            #1;
            check("rand_addr", 64'(m_rf_addr), 64'(addr_ref));
            check("rand_led", 64'(led), 64'(led_model(3'd0, ctrl_bits)));
        end

        // Directed display: memory browse word on channel 0
        @(negedge clk);
        sel = 3'd0;
        m_rf = 1'b1;
        m_data = 32'h1234ABCD;
        cyc(3);
        check_scan("disp_m", 32'h1234ABCD);

        // Directed display: watch channel 3 and control LEDs
        @(negedge clk);
        sel = 3'd3;
        ch_data[3*DATA_W +: DATA_W] = 32'hDEADBEEF;
        ctrl_bits = 16'hA5A5;
        cyc(3);
        #1;
        check("ch3_led", 64'(led), 64'hA5A5);
        check_scan("disp_ch3", 32'hDEADBEEF);

        // Random display traffic
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rs = 3'($urandom_range(0, 7));
            sel = rs;
            m_rf = 1'($urandom_range(0, 1));
            m_data = $urandom;
            rf_data = $urandom;
            for (int k = 0; k < NCH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom;
            ctrl_bits = 16'($urandom);
            if (rs == 3'd0) w = m_rf ? m_data : rf_data;
            else w = ch_data[rs*DATA_W +: DATA_W];
            cyc(3);
            #1;
            check("rnd_led", 64'(led), 64'(led_model(rs, ctrl_bits)));
            check_scan("rnd_disp", w);
        end

        // Asynchronous reset while running
        press(1'b1, 1'b0);
        @(negedge clk);
        run = 1'b1;
        waited = 0;
        while (!cpu_en && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("prerst_run", 64'(cpu_en), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_cpu_en", 64'(cpu_en), 64'd0);
        check("arst_an", 64'(seg_an), 64'hFF);
        check("arst_addr", 64'(m_rf_addr), 64'd0);
        check("arst_halted", 64'(halted_bp), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_unit_p.md
# dbg_unit_p

Parametrised debug unit for the multicycle CPU board build. It sits between the CPU top and the board I/O (switches, buttons, LEDs, 8-digit seven-segment display). It drives the CPU through a clock-enable (run / single-step / PC breakpoint) instead of a gated clock. It also provides a memory/register-file browse address and multiplexes NCH watch channels onto a scanned hex display.

## Interface
Parameters:
- DATA_W, 32, width of each watched word and of m_data/rf_data; DIGITS*4 must be >= DATA_W
- ADDR_W, 9, browse address width
- NCH, 8, number of watch channels (power of two, >= 2)
- DIGITS, 8, number of display digits (power of two)
- SCAN_W, 18, refresh counter width; digit index = top log2(DIGITS) bits
- DB_CYC, 4, debounce stability count (>= 1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  switch level: 1 = free-run, 0 = step mode
- step, inc, dec  in  1 each  raw pushbuttons
- m_rf  in  1  0 = show rf_data, 1 = show m_data on channel 0
- sel  in  log2(NCH)  watch channel select
- bp_en  in  1  breakpoint enable
- bp_addr  in  DATA_W  breakpoint PC
- pc  in  DATA_W  CPU PC
- m_data, rf_data  in  DATA_W  browse read data
- ch_data  in  NCH*DATA_W  watch words; channel k = bits [k*DATA_W +: DATA_W]; channel 0 is unused (replaced by browse data)
- ctrl_bits  in  16  CPU control-signal vector
- cpu_en  out  1  CPU clock enable
- halted_bp  out  1  sticky, set when the CPU was stopped by a breakpoint
- m_rf_addr  out  ADDR_W  browse address
- led  out  16  LED bus
- seg_ca  out  8  cathodes, active-low; bit7..bit1 = a..g, bit0 = dp
- seg_an  out  DIGITS  anodes, active-low one-hot

## Operation
- Button conditioning:
  - step, inc and dec each go through a 2-FF synchroniser, then a debouncer, then a rising-edge detector.
  - The debounced level flips after DB_CYC consecutive cycles of disagreement with the synchronised input.
  - The output is a one-cycle pulse.
  - run goes through a 2-FF synchroniser only.
- FSM states:
  - HALT: cpu_en=0.
    - If run is 1: go to RUN.
    - Else on a step pulse: go to STEP.
  - STEP: cpu_en=1 for exactly one cycle, then go to HALT.
  - RUN: cpu_en=1 every cycle.
    - If run is 0: go to HALT.
    - If bp_en, armed and pc==bp_addr: go to HALT, set halted_bp; cpu_en is 0 in that same cycle.
- Breakpoint arming:
  - armed is set in any cycle where pc != bp_addr.
  - armed is cleared on a breakpoint hit.
  - Effect: resuming at the breakpoint PC does not re-trigger until the PC has left it.
- halted_bp clears on entering RUN or STEP.
- Browse address:
  - An inc pulse adds 1 and a dec pulse subtracts 1, both modulo 2^ADDR_W (wraps both ways).
  - inc and dec pulses in the same cycle: no change.
- Display word:
  - sel==0: m_rf ? m_data : rf_data.
  - Otherwise: ch_data channel sel.
  - The word is zero-extended to DIGITS*4 bits and registered every cycle.
  - Digit i shows nibble i (digit 0 = least significant nibble).
- LEDs:
  - sel==0: led = m_rf_addr<<2, zero-extended or truncated to 16 bits.
  - Otherwise: led = ctrl_bits.
  - led is combinational from registered state and inputs.
- Hex encoding (active-low):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71.
  - dp is always off (bit0 = 1).

## Timing
- Reset values: FSM=HALT, cpu_en=0, halted_bp=0, armed=0, m_rf_addr=0, scan counter=0, display word=0, seg_an all ones, seg_ca=FF, debouncers at level 0.
- Button latency: a pulse asserts DB_CYC+3 cycles after a raw rising edge, given a clean, held input.
- FSM:
  - The step pulse is registered; cpu_en rises in the cycle after the pulse.
  - run has 2 cycles of synchroniser latency plus 1 cycle of FSM latency.
  - The breakpoint compare is combinational on pc; cpu_en drops in the cycle where pc matches.
- seg_an and seg_ca are registered and advance once per 2^(SCAN_W-log2(DIGITS)) cycles.
- Every digit is selected exactly once per full scan-counter period; no two anodes are ever low together.
- Reset assertion mid-RUN or mid-STEP: cpu_en drops asynchronously.

## Structure
- Package dbg_pkg holds:
  - the FSM state enum (HALT, STEP, RUN);
  - the 16-entry hex-to-segment constant;
  - the SEG_BLANK constant (8'hFF).
- One sub-module, btn_cond (synchroniser, debouncer, edge detect), instantiated three times.
- The FSM, address counter, display mux and scanner live in dbg_unit_p.

## Test plan
- Reset release, run=0, step held 20 cycles with DB_CYC=4: cpu_en high for exactly 1 cycle, 8 cycles after the step edge; FSM returns to HALT.
- run=1, bp_en=1, bp_addr=0x0C, pc sequence 0,4,8,0x0C: cpu_en=0 in the 0x0C cycle, halted_bp=1. Then run toggled 0→1 with pc held at 0x0C: CPU runs, no re-trigger until pc leaves 0x0C and returns.
- Three dec pulses from reset: m_rf_addr=0x1FD, led=0x07F4. inc and dec pulses in the same cycle: unchanged.
- sel=0, m_rf=1, m_data=0x1234ABCD, SCAN_W=6: anodes step FE,FD,...,7F; cathodes show D,C,b,A,4,3,2,1 with the codes above.
- sel=3, ch_data[3]=0xDEADBEEF, ctrl_bits=0xA5A5: led=0xA5A5, digits show F,E,E,b,D,A,E,d.
- Reset asserted mid-RUN: cpu_en, seg_an and m_rf_addr take their reset values immediately, without waiting for a clock edge.
